// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register bank read ports and the
// multiply/divide unit. The requester drives Start/Op/A/B and the unit
// returns Busy/Done/Hi/Lo/DivZero.
`timescale 1ns/1ps
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivZero;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, Hi, Lo, DivZero
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, Hi, Lo, DivZero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULTU/MULT/DIVU/DIV).
// One bit is resolved per clock over WIDTH cycles on magnitudes, then a
// single adjust cycle applies sign correction and loads Hi/Lo.
// Op[1] selects divide, Op[0] selects signed operation.
`timescale 1ns/1ps
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           Clk,
    input  logic           Rst_n,
    mul_div_unit_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ADJ  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;

    // Operation context captured at the Start edge
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;

    // Multiply: {partial product high, multiplier/low product bits}
    // Divide:   {partial remainder,   dividend/quotient bits}
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_divzero;

    logic               w_start;
    logic               w_last;
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_hi_adj;
    logic [WIDTH-1:0]   w_lo_adj;
    logic               w_busy;
    logic               w_done;

    // Start is only honoured when no operation is in flight
    assign w_start = bus.Start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // Signed ops work on magnitudes; unsigned ops pass operands through
    assign w_a_sgn = bus.Op[0] & bus.A[WIDTH-1];
    assign w_b_sgn = bus.Op[0] & bus.B[WIDTH-1];
    assign w_a_mag = w_a_sgn ? (~bus.A + 1'b1) : bus.A;
    assign w_b_mag = w_b_sgn ? (~bus.B + 1'b1) : bus.B;

    // Shift-add step: conditionally add multiplicand to the high half, then shift right
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: bring in the next dividend bit and try the subtraction
    assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge      = (w_trial >= {1'b0, r_opb});
    assign w_rem_nxt = w_ge ? (w_trial[WIDTH-1:0] - r_opb) : w_trial[WIDTH-1:0];
    assign w_div_nxt = {w_rem_nxt, r_acc[WIDTH-2:0], w_ge};

    // Sign correction and divide-by-zero substitution for the adjust cycle
    always_comb begin
        w_prod   = r_acc;
        if (r_op[0] && (r_sa ^ r_sb)) begin
            w_prod = ~r_acc + 1'b1;
        end
        w_hi_adj = w_prod[2*WIDTH-1:WIDTH];
        w_lo_adj = w_prod[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_divzero) begin
                w_hi_adj = r_a_raw;
                w_lo_adj = '1;
            end else begin
                w_hi_adj = r_acc[2*WIDTH-1:WIDTH];
                w_lo_adj = r_acc[WIDTH-1:0];
                if (r_op[0] && (r_sa ^ r_sb)) begin
                    w_lo_adj = ~r_acc[WIDTH-1:0] + 1'b1;
                end
                if (r_op[0] && r_sa) begin
                    w_hi_adj = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = bus.Start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_ADJ : S_RUN;
            S_ADJ:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = bus.Start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_ADJ:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Iteration counter: cleared on Start, advances once per RUN cycle
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand capture and per-cycle iteration of the accumulator
    always_ff @(posedge Clk) begin
        if (w_start) begin
            r_op    <= bus.Op;
            r_sa    <= w_a_sgn;
            r_sb    <= w_b_sgn;
            r_a_raw <= bus.A;
            r_opa   <= w_a_mag;
            r_opb   <= w_b_mag;
            r_acc   <= bus.Op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
        end else if (r_state == S_RUN) begin
            r_acc   <= r_op[1] ? w_div_nxt : w_mul_nxt;
        end
    end

    // Visible results: DivZero updates at Start, Hi/Lo only in the adjust cycle
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_divzero <= 1'b0;
        end else if (w_start) begin
            r_divzero <= bus.Op[1] && (bus.B == '0);
        end else if (r_state == S_ADJ) begin
            r_hi      <= w_hi_adj;
            r_lo      <= w_lo_adj;
        end
    end

    assign bus.Busy    = w_busy;
    assign bus.Done    = w_done;
    assign bus.Hi      = r_hi;
    assign bus.Lo      = r_lo;
    assign bus.DivZero = r_divzero;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases plus randomized ops,
// expected results from a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mul_div_unit;

    localparam int W = 32;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    always #5 Clk = ~Clk;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int n_checks      = 0;
    int n_pass        = 0;
    int n_done        = 0;
    int n_expect_done = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: {DivZero, Hi, Lo} from ordinary 64-bit arithmetic
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: p = sa * sb;
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    p = {a % b, a / b};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {sr[31:0], sq[31:0]};
                end
            end
        endcase
        return {(op[1] && (b == 32'd0)), p};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op; returns at the negedge where Done is seen (or on timeout)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit imm, input bit poke, output int lat, output int busy_cyc);
        exp_q.push_back(model(op, a, b));
        n_expect_done++;
        if (!imm) @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge Clk);
        lat      = 1;
        busy_cyc = 0;
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.Op    = 2'($urandom);
        chk("busy_after_start", bus.Busy, 1);
        chk("done_low_after_start", bus.Done, 0);
        while (!bus.Done && lat < 40) begin
            if (bus.Busy) busy_cyc++;
            if (poke && lat == 5) begin
                bus.Start = 1'b1;
                bus.Op    = 2'b00;
                bus.A     = 32'd3;
                bus.B     = 32'd3;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        chk("latency", 64'(lat), 64'd34);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},    bus.Busy, 0);
        chk({tag, "_done"},    bus.Done, 0);
        chk({tag, "_hi"},      bus.Hi, 0);
        chk({tag, "_lo"},      bus.Lo, 0);
        chk({tag, "_divzero"}, bus.DivZero, 0);
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge Clk);
            if (Rst_n && bus.Done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("done_expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("hi",      bus.Hi,      mon_e[63:32]);
                    chk("lo",      bus.Lo,      mon_e[31:0]);
                    chk("divzero", bus.DivZero, mon_e[64]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat, bc;
        bus.Start = 1'b0;
        bus.Op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;

        repeat (3) @(posedge Clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        // Directed cases
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, bc);
        chk("busy_cycles", 64'(bc), 64'd33);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, lat, bc);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, bc);
        run_op(2'b10, 32'h0000_0064, 32'd0, 0, 0, lat, bc);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, bc);

        // Start while busy must be ignored
        run_op(2'b10, 32'd100, 32'd7, 0, 1, lat, bc);
        repeat (40) @(negedge Clk);

        // Asynchronous reset in the middle of RUN
        exp_q.push_back(model(2'b00, 32'd6, 32'd7));
        n_expect_done++;
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = 2'b00;
        bus.A     = 32'd6;
        bus.B     = 32'd7;
        @(posedge Clk);
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (9) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        exp_q.delete();
        n_expect_done--;
        #1;
        chk_zero_outputs("midrun_reset");
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (40) @(negedge Clk);
        run_op(2'b00, 32'd6, 32'd7, 0, 0, lat, bc);

        // Back-to-back: Start held in DONE
        run_op(2'b01, 32'h1234_5678, 32'hFFFF_0001, 1, 0, lat, bc);
        run_op(2'b11, 32'hF000_0001, 32'd13, 1, 0, lat, bc);

        // Randomized operations
        repeat (40) begin
            run_op(2'($urandom), pick_operand(), pick_operand(),
                   bit'($urandom_range(0, 1)), 0, lat, bc);
        end

        repeat (5) @(negedge Clk);
        chk("done_count", 64'(n_done), 64'(n_expect_done));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
